// File: rtl/sram_arb_2p_if.sv
// Requester and SRAM-side signal bundle for the two-port SRAM arbiter.
// slave is the arbiter's view; master is the requesters/SRAM-macro view.
interface sram_arb_2p_if #(
    parameter int unsigned DATA_W = 152,
    parameter int unsigned ADDR_W = 4
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              gnt0;
    logic              gnt1;
    logic              rvalid0;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic              CEN;
    logic              WEN;
    logic [ADDR_W-1:0] A;
    logic [DATA_W-1:0] D;
    logic [DATA_W-1:0] Q;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, Q,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, CEN, WEN, A, D
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, Q,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, CEN, WEN, A, D
    );
endinterface

// File: rtl/sram_arb_2p.sv
// Round-robin arbiter sharing one single-port SRAM between two requesters.
// Grants and SRAM controls are combinational; read data returns the next cycle.
module sram_arb_2p #(
    parameter int unsigned DATA_W = 152,
    parameter int unsigned ADDR_W = 4
) (
    input  logic          CLK,
    input  logic          RESET_N,
    sram_arb_2p_if.slave  bus
);

    logic              r_last_gnt;
    logic              r_pend0;
    logic              r_pend1;
    logic [DATA_W-1:0] r_hold0;
    logic [DATA_W-1:0] r_hold1;

    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_rvalid0;
    logic              w_rvalid1;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_we;

    // Requester 0 wins a tie only when requester 1 was granted last.
    always_comb begin
        w_gnt0    = RESET_N & bus.req0 & (~bus.req1 | r_last_gnt);
        w_gnt1    = RESET_N & bus.req1 & ~w_gnt0;
        w_rvalid0 = RESET_N & r_pend0;
        w_rvalid1 = RESET_N & r_pend1;
    end

    always_comb begin
        w_addr  = '0;
        w_wdata = '0;
        w_we    = 1'b0;
        if (w_gnt0) begin
            w_addr  = bus.addr0;
            w_wdata = bus.wdata0;
            w_we    = bus.we0;
        end else if (w_gnt1) begin
            w_addr  = bus.addr1;
            w_wdata = bus.wdata1;
            w_we    = bus.we1;
        end
    end

    assign bus.CEN     = ~(w_gnt0 | w_gnt1);
    assign bus.WEN     = ~w_we;
    assign bus.A       = w_addr;
    assign bus.D       = w_wdata;
    assign bus.gnt0    = w_gnt0;
    assign bus.gnt1    = w_gnt1;
    assign bus.rvalid0 = w_rvalid0;
    assign bus.rvalid1 = w_rvalid1;
    assign bus.rdata0  = w_rvalid0 ? bus.Q : r_hold0;
    assign bus.rdata1  = w_rvalid1 ? bus.Q : r_hold1;

    // Track pending reads, capture returned data per requester, remember last winner.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_last_gnt <= 1'b1;
            r_pend0    <= 1'b0;
            r_pend1    <= 1'b0;
            r_hold0    <= '0;
            r_hold1    <= '0;
        end else begin
            r_pend0 <= w_gnt0 & ~bus.we0;
            r_pend1 <= w_gnt1 & ~bus.we1;
            if (r_pend0) r_hold0 <= bus.Q;
            if (r_pend1) r_hold1 <= bus.Q;
            if (w_gnt0 | w_gnt1) r_last_gnt <= w_gnt1;
        end
    end

endmodule

// File: tb/tb_sram_arb_2p.sv
// Bench for sram_arb_2p: directed scenarios plus random traffic against a
// transaction-level reference of the arbiter and a behavioural SRAM macro.
module tb_sram_arb_2p;
    localparam int unsigned DW = 152;
    localparam int unsigned AW = 4;

    logic CLK = 1'b0;
    logic RESET_N;
    always #5 CLK = ~CLK;

    sram_arb_2p_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
    sram_arb_2p #(.DATA_W(DW), .ADDR_W(AW)) dut (.CLK(CLK), .RESET_N(RESET_N), .bus(bus));

    // SRAM macro: write or read on the rising edge, Q valid the following cycle.
    logic [DW-1:0] sram [16];
    always @(posedge CLK) begin
        if (bus.CEN == 1'b0) begin
            if (bus.WEN == 1'b0) sram[bus.A] <= bus.D;
            else                 bus.Q       <= sram[bus.A];
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: who won last, outstanding read per requester, last read data.
    int            m_last = 1;
    bit            m_pend [2];
    logic [DW-1:0] m_pdata[2];
    logic [DW-1:0] m_hold [2];
    logic [DW-1:0] ref_mem[16];

    bit            c_rst;
    bit            c_req [2];
    bit            c_we  [2];
    logic [AW-1:0] c_addr[2];
    logic [DW-1:0] c_wd  [2];

    int            e_win;
    bit            e_gnt[2];
    bit            e_cen, e_wen;
    logic [AW-1:0] e_a;
    logic [DW-1:0] e_d;
    bit            e_rv [2];
    logic [DW-1:0] e_rd [2];

    function automatic logic [DW-1:0] rand_word();
        logic [159:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return t[DW-1:0];
    endfunction

    // Apply one cycle of inputs after the falling edge and derive expectations.
    task automatic drive(input bit rst, input bit r0, input bit w0, input logic [AW-1:0] a0,
                         input logic [DW-1:0] d0, input bit r1, input bit w1,
                         input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        @(negedge CLK);
        RESET_N = rst;
        bus.req0 = r0; bus.we0 = w0; bus.addr0 = a0; bus.wdata0 = d0;
        bus.req1 = r1; bus.we1 = w1; bus.addr1 = a1; bus.wdata1 = d1;
        c_rst = rst;
        c_req[0] = r0; c_we[0] = w0; c_addr[0] = a0; c_wd[0] = d0;
        c_req[1] = r1; c_we[1] = w1; c_addr[1] = a1; c_wd[1] = d1;
        if (!rst)             e_win = -1;
        else if (r0 && r1)    e_win = (m_last == 0) ? 1 : 0;
        else if (r0)          e_win = 0;
        else if (r1)          e_win = 1;
        else                  e_win = -1;
        e_gnt[0] = (e_win == 0);
        e_gnt[1] = (e_win == 1);
        if (e_win < 0) begin
            e_cen = 1'b1; e_wen = 1'b1; e_a = '0; e_d = '0;
        end else begin
            e_cen = 1'b0; e_wen = !c_we[e_win]; e_a = c_addr[e_win]; e_d = c_wd[e_win];
        end
        for (int x = 0; x < 2; x++) begin
            e_rv[x] = rst && m_pend[x];
            e_rd[x] = e_rv[x] ? m_pdata[x] : m_hold[x];
        end
        #1;
    endtask

    // Advance through the rising edge and apply its effect to the reference.
    task automatic tick();
        @(posedge CLK);
        if (!c_rst) begin
            m_last = 1;
            for (int x = 0; x < 2; x++) begin m_pend[x] = 0; m_hold[x] = '0; end
        end else begin
            for (int x = 0; x < 2; x++) begin
                if (m_pend[x]) m_hold[x] = m_pdata[x];
                m_pend[x] = 0;
            end
            if (e_win >= 0) begin
                if (c_we[e_win]) ref_mem[c_addr[e_win]] = c_wd[e_win];
                else begin
                    m_pend[e_win]  = 1;
                    m_pdata[e_win] = ref_mem[c_addr[e_win]];
                end
                m_last = e_win;
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b1, 1'b0, AW'(3), rand_word(), 1'b1, 1'b0, AW'(5), rand_word());
            if ({bus.gnt0, bus.gnt1} !== 2'b00) begin n_err++; $display("FAIL reset gnt: got %b want 00", {bus.gnt0, bus.gnt1}); end n_cmp++;
            if ({bus.CEN, bus.WEN} !== 2'b11) begin n_err++; $display("FAIL reset cen/wen: got %b want 11", {bus.CEN, bus.WEN}); end n_cmp++;
            if (bus.A !== '0 || bus.D !== '0) begin n_err++; $display("FAIL reset a/d: got %0h/%0h want 0/0", bus.A, bus.D); end n_cmp++;
            if ({bus.rvalid0, bus.rvalid1} !== 2'b00) begin n_err++; $display("FAIL reset rvalid: got %b want 00", {bus.rvalid0, bus.rvalid1}); end n_cmp++;
            tick();
        end
        drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        if (bus.rdata0 !== '0 || bus.rdata1 !== '0) begin n_err++; $display("FAIL reset hold: got %0h/%0h want 0/0", bus.rdata0, bus.rdata1); end n_cmp++;
        tick();
    endtask

    task automatic test_rr_reads();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 1'b0, AW'(3), '0, 1'b1, 1'b0, AW'(5), '0);
            if (bus.gnt0 !== ((i % 2) == 0) || bus.gnt1 !== ((i % 2) == 1)) begin n_err++; $display("FAIL rr gnt cyc %0d: got %b%b want %b%b", i, bus.gnt0, bus.gnt1, (i % 2) == 0, (i % 2) == 1); end n_cmp++;
            if (bus.CEN !== 1'b0 || bus.A !== e_a) begin n_err++; $display("FAIL rr cen/a cyc %0d: got %b/%0h want 0/%0h", i, bus.CEN, bus.A, e_a); end n_cmp++;
            if (bus.rvalid0 !== e_rv[0] || bus.rvalid1 !== e_rv[1]) begin n_err++; $display("FAIL rr rvalid cyc %0d: got %b%b want %b%b", i, bus.rvalid0, bus.rvalid1, e_rv[0], e_rv[1]); end n_cmp++;
            if (bus.rdata0 !== e_rd[0] || bus.rdata1 !== e_rd[1]) begin n_err++; $display("FAIL rr rdata cyc %0d: got %0h/%0h want %0h/%0h", i, bus.rdata0, bus.rdata1, e_rd[0], e_rd[1]); end n_cmp++;
            tick();
        end
        drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        if (bus.rvalid1 !== 1'b1 || bus.rdata1 !== ref_mem[5]) begin n_err++; $display("FAIL rr last read: got %b/%0h want 1/%0h", bus.rvalid1, bus.rdata1, ref_mem[5]); end n_cmp++;
        tick();
    endtask

    task automatic test_write_then_read();
        drive(1'b1, 1'b1, 1'b1, AW'(2), DW'('hA5), 1'b0, 1'b0, '0, '0);
        if (bus.gnt0 !== 1'b1 || bus.WEN !== 1'b0 || bus.A !== AW'(2) || bus.D !== DW'('hA5)) begin n_err++; $display("FAIL wr grant: got gnt%b wen%b a%0h d%0h want 1 0 2 a5", bus.gnt0, bus.WEN, bus.A, bus.D); end n_cmp++;
        tick();
        drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, AW'(2), '0);
        if (bus.gnt1 !== 1'b1 || bus.WEN !== 1'b1 || bus.rvalid0 !== 1'b0) begin n_err++; $display("FAIL wr rd grant: got gnt1 %b wen %b rv0 %b want 1 1 0", bus.gnt1, bus.WEN, bus.rvalid0); end n_cmp++;
        tick();
        drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        if (bus.rvalid1 !== 1'b1 || bus.rdata1 !== DW'('hA5) || bus.rvalid0 !== 1'b0) begin n_err++; $display("FAIL wr readback: got rv1 %b rd1 %0h rv0 %b want 1 a5 0", bus.rvalid1, bus.rdata1, bus.rvalid0); end n_cmp++;
        tick();
        drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        if (bus.rvalid1 !== 1'b0 || bus.rdata1 !== DW'('hA5)) begin n_err++; $display("FAIL wr hold: got %b/%0h want 0/a5", bus.rvalid1, bus.rdata1); end n_cmp++;
        tick();
    endtask

    task automatic test_hold_isolation();
        drive(1'b1, 1'b1, 1'b1, AW'(1), DW'('h11), 1'b0, 1'b0, '0, '0); tick();
        drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, AW'(4), DW'('h44)); tick();
        drive(1'b1, 1'b1, 1'b0, AW'(1), '0, 1'b0, 1'b0, '0, '0);
        if (bus.rvalid0 !== 1'b0 || bus.rvalid1 !== 1'b0) begin n_err++; $display("FAIL hold write rvalid: got %b%b want 00", bus.rvalid0, bus.rvalid1); end n_cmp++;
        tick();
        drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, AW'(4), '0);
        if (bus.rvalid0 !== 1'b1 || bus.rdata0 !== DW'('h11)) begin n_err++; $display("FAIL hold rd0: got %b/%0h want 1/11", bus.rvalid0, bus.rdata0); end n_cmp++;
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
            if (bus.rdata0 !== DW'('h11) || bus.rdata1 !== DW'('h44) || bus.rvalid1 !== (i == 0)) begin n_err++; $display("FAIL hold iso cyc %0d: got %0h/%0h rv1 %b want 11/44 %b", i, bus.rdata0, bus.rdata1, bus.rvalid1, i == 0); end n_cmp++;
            tick();
        end
    endtask

    task automatic test_single_req();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, AW'(7), '0);
            if (bus.gnt1 !== 1'b1 || bus.gnt0 !== 1'b0) begin n_err++; $display("FAIL single cyc %0d: got %b%b want 01", i, bus.gnt0, bus.gnt1); end n_cmp++;
            tick();
        end
        drive(1'b1, 1'b1, 1'b0, AW'(6), '0, 1'b1, 1'b0, AW'(7), '0);
        if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0) begin n_err++; $display("FAIL single tie: got %b%b want 10", bus.gnt0, bus.gnt1); end n_cmp++;
        tick();
    endtask

    task automatic test_reset_mid_read();
        drive(1'b1, 1'b1, 1'b0, AW'(1), '0, 1'b0, 1'b0, '0, '0); tick();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b1, 1'b0, AW'(1), '0, 1'b1, 1'b0, AW'(4), '0);
            if (bus.rvalid0 !== 1'b0 || bus.rvalid1 !== 1'b0 || bus.CEN !== 1'b1 || bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b0) begin n_err++; $display("FAIL rstmid cyc %0d: got rv %b%b cen %b gnt %b%b want 00 1 00", i, bus.rvalid0, bus.rvalid1, bus.CEN, bus.gnt0, bus.gnt1); end n_cmp++;
            if (i == 1 && (bus.rdata0 !== '0 || bus.rdata1 !== '0)) begin n_err++; $display("FAIL rstmid rdata: got %0h/%0h want 0/0", bus.rdata0, bus.rdata1); end
            if (i == 1) n_cmp++;
            tick();
        end
        drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        if (bus.rvalid0 !== 1'b0 || bus.rdata0 !== '0) begin n_err++; $display("FAIL rstmid after: got %b/%0h want 0/0", bus.rvalid0, bus.rdata0); end n_cmp++;
        tick();
    endtask

    task automatic test_idle();
        for (int w = 0; w < 2; w++) begin
            drive(1'b1, w == 0, 1'b0, AW'(2), '0, w == 1, 1'b0, AW'(3), '0); tick();
            for (int i = 0; i < 5; i++) begin
                drive(1'b1, 1'b0, 1'b0, AW'($urandom_range(0, 15)), rand_word(), 1'b0, 1'b1, AW'($urandom_range(0, 15)), rand_word());
                if ({bus.CEN, bus.WEN, bus.gnt0, bus.gnt1} !== 4'b1100 || bus.A !== '0 || bus.D !== '0) begin n_err++; $display("FAIL idle w%0d cyc %0d: got cen%b wen%b gnt%b%b a%0h d%0h want 1 1 00 0 0", w, i, bus.CEN, bus.WEN, bus.gnt0, bus.gnt1, bus.A, bus.D); end n_cmp++;
                tick();
            end
            drive(1'b1, 1'b1, 1'b0, AW'(2), '0, 1'b1, 1'b0, AW'(3), '0);
            if (bus.gnt0 !== (w == 1) || bus.gnt1 !== (w == 0)) begin n_err++; $display("FAIL idle tie w%0d: got %b%b want %b%b", w, bus.gnt0, bus.gnt1, w == 1, w == 0); end n_cmp++;
            tick();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 49) != 0,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, AW'($urandom_range(0, 3)), rand_word(),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, AW'($urandom_range(0, 3)), rand_word());
            if (bus.gnt0 !== e_gnt[0] || bus.gnt1 !== e_gnt[1]) begin n_err++; $display("FAIL rnd gnt cyc %0d: got %b%b want %b%b", i, bus.gnt0, bus.gnt1, e_gnt[0], e_gnt[1]); end n_cmp++;
            if (bus.CEN !== e_cen || bus.WEN !== e_wen) begin n_err++; $display("FAIL rnd cen/wen cyc %0d: got %b%b want %b%b", i, bus.CEN, bus.WEN, e_cen, e_wen); end n_cmp++;
            if (bus.A !== e_a || bus.D !== e_d) begin n_err++; $display("FAIL rnd a/d cyc %0d: got %0h/%0h want %0h/%0h", i, bus.A, bus.D, e_a, e_d); end n_cmp++;
            if (bus.rvalid0 !== e_rv[0] || bus.rvalid1 !== e_rv[1]) begin n_err++; $display("FAIL rnd rvalid cyc %0d: got %b%b want %b%b", i, bus.rvalid0, bus.rvalid1, e_rv[0], e_rv[1]); end n_cmp++;
            if (bus.rdata0 !== e_rd[0]) begin n_err++; $display("FAIL rnd rdata0 cyc %0d: got %0h want %0h", i, bus.rdata0, e_rd[0]); end n_cmp++;
            if (bus.rdata1 !== e_rd[1]) begin n_err++; $display("FAIL rnd rdata1 cyc %0d: got %0h want %0h", i, bus.rdata1, e_rd[1]); end n_cmp++;
            tick();
        end
    endtask

    initial begin
        logic [DW-1:0] w;
        RESET_N = 1'b0;
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
        for (int i = 0; i < 16; i++) begin
            w = rand_word();
            sram[i] <= w;
            ref_mem[i] = w;
        end
        test_reset();
        test_rr_reads();
        test_write_then_read();
        test_hold_isolation();
        test_single_req();
        test_reset_mid_read();
        test_idle();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/sram_arb_2p.md
SRAM_ARB_2P -- requirements
Module: sram_arb_2p

Interface
REQ-001 Parameter DATA_W, default 152, SRAM word width.
REQ-002 Parameter ADDR_W, default 4, SRAM address width (16 words).
REQ-003 Port CLK  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port RESET_N  input  1  reset: synchronous, active-low.
REQ-005 Ports req0/req1  input  1  requester 0/1 access request, level, held until granted.
REQ-006 Ports we0/we1  input  1  1 = write, 0 = read; qualified by req.
REQ-007 Ports addr0/addr1  input  ADDR_W  requester word address.
REQ-008 Ports wdata0/wdata1  input  DATA_W  requester write data.
REQ-009 Ports gnt0/gnt1  output  1  access accepted this cycle (combinational).
REQ-010 Ports rvalid0/rvalid1  output  1  read data valid this cycle.
REQ-011 Ports rdata0/rdata1  output  DATA_W  read data for the requester.
REQ-012 Port CEN  output  1  SRAM chip enable, active-low.
REQ-013 Port WEN  output  1  SRAM write enable, 0 = write, 1 = read.
REQ-014 Port A  output  ADDR_W  SRAM address.
REQ-015 Port D  output  DATA_W  SRAM write data.
REQ-016 Port Q  input  DATA_W  SRAM read data; valid the cycle after a read edge.

Function
REQ-017 The arbiter shall grant at most one requester per cycle; gnt0 & gnt1 is never 1.
REQ-018 Exactly one requesting: that requester shall be granted in the same cycle.
REQ-019 Both requesting: the requester not granted most recently shall be granted (round-robin).
REQ-020 Register last_gnt shall update to the granted index only on a grant cycle; idle cycles leave it unchanged.
REQ-021 On grant: CEN=0, WEN=~we_x, A=addr_x, D=wdata_x from the winner, combinationally; the SRAM access completes at that cycle's rising edge.
REQ-022 No grant: CEN=1, WEN=1, A=0, D=0.
REQ-023 Read granted in cycle N: rvalid_x=1 in cycle N+1 only, with rdata_x=Q in that cycle.
REQ-024 In cycle N+1 of a read the arbiter shall capture Q into per-requester hold register hold_x.
REQ-025 When rvalid_x=0, rdata_x shall equal hold_x (last completed read for that requester, unaffected by the other requester's reads).
REQ-026 Writes shall produce no rvalid; hold registers are unchanged by writes.
REQ-027 Throughput: one access per cycle; back-to-back reads by alternating requesters give rvalid on consecutive cycles to the matching requester.
REQ-028 Write in cycle N then read of the same address in N+1 (either requester) shall return the new data in N+2.
REQ-029 A requester holding req continuously while the other also requests shall be granted at least every second cycle (no starvation).
REQ-030 req deasserted without a grant is legal; no state changes result.

Reset
REQ-031 While RESET_N=0 at a rising edge: last_gnt=1 (requester 0 wins the first tie), pending rvalid cleared, hold0=hold1=0.
REQ-032 While RESET_N=0: gnt0=gnt1=0, CEN=1, WEN=1, A=0, D=0, rvalid0=rvalid1=0, regardless of req.
REQ-033 A read granted in the cycle before a reset edge shall produce no rvalid after reset.
REQ-034 SRAM contents are not reset by this block.

Verification
REQ-035 Reset, then req0=req1=1 reads (addr0=3, addr1=5), held 4 cycles -> gnt pattern 0,1,0,1; CEN=0 every cycle.
REQ-036 req0 write addr 2 data 0xA5 (zero-extended), next cycle req1 read addr 2 -> rvalid1=1 two cycles after the write grant, rdata1=0xA5; rvalid0 stays 0.
REQ-037 req0 read addr 1 (holds 0x11), then req1 read addr 4 (holds 0x44) -> rdata0 stays 0x11 while rdata1 becomes 0x44.
REQ-038 Only req1 held 3 cycles -> gnt1=1 each cycle, gnt0=0; then a both-request tie -> gnt0 wins.
REQ-039 Read granted, RESET_N=0 at next edge -> rvalid0=rvalid1=0, rdata0=rdata1=0, CEN=1 during reset.
REQ-040 No requests 5 cycles -> CEN=1, WEN=1, A=0, D=0, gnt=0, last_gnt unchanged (next tie goes to the requester not granted last).
